// File: rtl/hazard_forward_unit.sv
// Operand-forwarding and load/CSR-use hazard control for the ID/EX boundary of the 5-stage PCPU.
// Tracks the destinations of the EX, MEM and WB stages and registers the EX operand-mux selects.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wb_en,
    input  logic [1:0]            id_wb_kind,
    input  logic                  ex_redirect,
    input  logic                  dcache_stall,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic [CNT_W-1:0]      hazard_stall_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wb_en;
        logic [1:0]            kind;
    } slot_t;

    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_CSR  = 2'b10;
    localparam logic [1:0] KIND_LINK = 2'b11;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_LINK  = 2'b11;

    // Index 0 = ID/EX (S_EX), 1 = EX/MEM (S_MEM), 2 = MEM/WB (S_WB).
    slot_t slots [3];

    logic       ex_slow;
    logic       dep_rs1;
    logic       dep_rs2;
    logic       use_hazard;
    logic       enter;
    slot_t      id_slot;
    logic [1:0] next_sel_a;
    logic [1:0] next_sel_b;

    function automatic logic is_producer(input slot_t s, input logic [REG_ADDR_W-1:0] r);
        is_producer = s.valid && s.wb_en && (s.rd == r) && (r != '0);
    endfunction

    // Nearest producer wins; WB producers are covered by the write-through register file.
    function automatic logic [1:0] select_for(input logic used,
                                              input logic [REG_ADDR_W-1:0] r,
                                              input slot_t ex_s,
                                              input slot_t mem_s);
        logic [1:0] sel;
        sel = SEL_RF;
        if (used) begin
            if (is_producer(ex_s, r)) begin
                sel = (ex_s.kind == KIND_LINK) ? SEL_LINK : SEL_EXMEM;
            end else if (is_producer(mem_s, r)) begin
                sel = SEL_MEMWB;
            end
        end
        select_for = sel;
    endfunction

    always_comb begin
        ex_slow    = (slots[0].kind == KIND_LOAD) || (slots[0].kind == KIND_CSR);
        dep_rs1    = id_use_rs1 && is_producer(slots[0], id_rs1);
        dep_rs2    = id_use_rs2 && is_producer(slots[0], id_rs2);
        use_hazard = id_valid && !ex_redirect && ex_slow && (dep_rs1 || dep_rs2);
        enter      = id_valid && !use_hazard && !ex_redirect;

        id_slot       = '0;
        id_slot.valid = enter;
        id_slot.rd    = id_rd;
        id_slot.wb_en = id_wb_en;
        id_slot.kind  = id_wb_kind;
        if (!enter) begin
            id_slot = '0;
        end

        next_sel_a = enter ? select_for(id_use_rs1, id_rs1, slots[0], slots[1]) : SEL_RF;
        next_sel_b = enter ? select_for(id_use_rs2, id_rs2, slots[0], slots[1]) : SEL_RF;

        stall_if_id  = dcache_stall || use_hazard;
        bubble_id_ex = !dcache_stall && (use_hazard || ex_redirect);
    end

    // Stage boundary: ID -> EX; the whole scoreboard freezes on a D-cache miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                slots[i] <= '0;
            end
            fwd_sel_a        <= SEL_RF;
            fwd_sel_b        <= SEL_RF;
            hazard_stall_cnt <= '0;
        end else if (!dcache_stall) begin
            slots[2]         <= slots[1];
            slots[1]         <= slots[0];
            slots[0]         <= id_slot;
            fwd_sel_a        <= next_sel_a;
            fwd_sel_b        <= next_sel_b;
            hazard_stall_cnt <= hazard_stall_cnt + {{(CNT_W-1){1'b0}}, use_hazard};
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed pipeline scenarios plus random traffic,
// checked against an in-flight instruction list model.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wb_en = 1'b0;
    logic [1:0]  id_wb_kind = '0;
    logic        ex_redirect = 1'b0, dcache_stall = 1'b0;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall_if_id, bubble_id_ex;
    logic [31:0] hazard_stall_cnt;

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_wb_en(id_wb_en), .id_wb_kind(id_wb_kind), .ex_redirect(ex_redirect),
        .dcache_stall(dcache_stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .hazard_stall_cnt(hazard_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wb;
        bit [1:0] kind;
    } ins_t;

    typedef struct {
        bit          stall;
        bit          bubble;
        bit [1:0]    sa;
        bit [1:0]    sb;
        int unsigned cnt;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    ins_t        pipe[3];       // in-flight instructions by age: EX, MEM, WB
    bit [1:0]    m_sa, m_sb;
    int unsigned m_cnt;
    int          total = 0;
    int          bad = 0;

    function automatic bit writes(ins_t s, bit [4:0] r);
        return s.v && s.wb && s.rd == r && r != 0;
    endfunction

    // Walk from youngest to oldest forwardable producer (EX, then MEM).
    function automatic bit [1:0] want_sel(bit entering, bit used, bit [4:0] r);
        if (!entering || !used) return 2'd0;
        for (int age = 0; age < 2; age++) begin
            if (writes(pipe[age], r)) begin
                if (age == 1) return 2'd2;
                return (pipe[age].kind == 2'd3) ? 2'd3 : 2'd1;
            end
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_sa = 0; m_sb = 0; m_cnt = 0;
    endtask

    task automatic cyc(input bit v, input bit [4:0] r1, input bit [4:0] r2,
                       input bit u1, input bit u2, input bit [4:0] rd, input bit wb,
                       input bit [1:0] k, input bit redir, input bit ds, input string tag);
        exp_t e;
        bit   hz, enter;
        bit [1:0] na, nb;
        @(posedge clk); #1;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_wb_en = wb; id_wb_kind = k; ex_redirect = redir; dcache_stall = ds;
        hz = v && !redir && (pipe[0].kind == 2'd1 || pipe[0].kind == 2'd2) &&
             ((u1 && writes(pipe[0], r1)) || (u2 && writes(pipe[0], r2)));
        e.stall = ds || hz;
        e.bubble = !ds && (hz || redir);
        e.sa = m_sa; e.sb = m_sb; e.cnt = m_cnt; e.tag = tag;
        sb_q.push_back(e);
        if (!ds) begin
            enter = v && !hz && !redir;
            na = want_sel(enter, u1, r1);
            nb = want_sel(enter, u2, r2);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = enter ? '{1, rd, wb, k} : '{0, 0, 0, 0};
            m_sa = na; m_sb = nb;
            m_cnt = m_cnt + (hz ? 1 : 0);
        end
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic pulse_reset(input string tag);
        exp_t e;
        @(posedge clk); #1;
        id_valid = 0; ex_redirect = 0; dcache_stall = 0;
        rst = 1;
        model_reset();
        #2 rst = 0;
        e.stall = 0; e.bubble = 0; e.sa = 0; e.sb = 0; e.cnt = 0; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s/%s t=%0t got=%0d want=%0d", tag, name, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("stall_if_id", e.tag, int'(stall_if_id), int'(e.stall));
                chk("bubble_id_ex", e.tag, int'(bubble_id_ex), int'(e.bubble));
                chk("fwd_sel_a", e.tag, int'(fwd_sel_a), int'(e.sa));
                chk("fwd_sel_b", e.tag, int'(fwd_sel_b), int'(e.sb));
                chk("cnt", e.tag, int'(hazard_stall_cnt), int'(e.cnt));
            end
        end
    end

    initial begin : stimulus
        bit [1:0] k;
        model_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        idle("reset");
        // ALU producer then consumer on rs1
        cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, "alu_add");
        cyc(1, 5, 3, 1, 1, 8, 1, 0, 0, 0, "alu_sub");
        idle("alu_fwd");
        idle("alu_drain");
        // load-use: one bubble then MEM/WB forwarding
        cyc(1, 1, 2, 1, 1, 6, 1, 1, 0, 0, "lw");
        cyc(1, 6, 6, 1, 1, 7, 1, 0, 0, 0, "lu_stall");
        cyc(1, 6, 6, 1, 1, 7, 1, 0, 0, 0, "lu_enter");
        idle("lu_fwd");
        idle("lu_drain");
        // link forwarding, then x0 never forwards or stalls
        cyc(1, 0, 0, 0, 0, 1, 1, 3, 0, 0, "jal");
        cyc(1, 1, 1, 1, 0, 9, 1, 0, 0, 0, "use_x1");
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, "lw_x0");
        cyc(1, 0, 0, 1, 1, 4, 1, 0, 0, 0, "use_x0");
        idle("x0_fwd");
        idle("x0_drain");
        // load-use under a 4-cycle D-cache freeze
        cyc(1, 2, 3, 1, 1, 6, 1, 1, 0, 0, "lw_ds");
        repeat (4) cyc(1, 6, 6, 1, 1, 7, 1, 0, 0, 1, "ds_frozen");
        cyc(1, 6, 6, 1, 1, 7, 1, 0, 0, 0, "ds_bubble");
        cyc(1, 6, 6, 1, 1, 7, 1, 0, 0, 0, "ds_enter");
        idle("ds_fwd");
        idle("ds_drain");
        // redirect overrides the load-use hazard
        cyc(1, 2, 3, 1, 1, 6, 1, 1, 0, 0, "lw_rd");
        cyc(1, 6, 6, 1, 1, 7, 1, 0, 1, 0, "redirect");
        cyc(1, 6, 0, 1, 0, 7, 1, 0, 0, 0, "after_redir");
        idle("redir_fwd");
        // async reset mid-sequence
        cyc(1, 2, 3, 1, 1, 6, 1, 1, 0, 0, "lw_pre_rst");
        cyc(1, 6, 6, 1, 1, 7, 1, 0, 0, 0, "stall_pre_rst");
        pulse_reset("mid_reset");
        cyc(1, 6, 6, 1, 1, 7, 1, 0, 0, 0, "first_after_rst");
        idle("first_after_rst_sel");
        // random traffic on a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            k = 2'($urandom_range(0, 3));
            if (i == 200) pulse_reset("rand_reset");
            cyc($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 8, k, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 2, "random");
        end
        idle("final");
        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
